alarm_set: RTL and testbench

ALARM_SET -- requirements
Module: alarm_set

---
 rtl/alarm_set.sv | 168 ++++++++++++++++
 tb/tb_alarm_set.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_set.sv
// Alarm-set editor: debounced keys edit a BCD hh:mm:ss working copy that is committed to alarm_R on ok.
// Latency: key press pulse ~DEB_MAX+4 cycles after the raw edge; alarm_R/alarm_ready_R_clk one cycle after the ok pulse.
// Backpressure: none; key pulses outside EDIT are dropped, and same-cycle pulses resolve ok > sel > inc > dec.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   ALARM_R                  editing allowed while high (from the state controller)
//   key_{sel,inc,dec,ok}_n   raw active-low push buttons
//   alarm_R                  committed alarm, BCD {h10,h1,m10,m1,s10,s1}
//   alarm_ready_R_clk        one-cycle commit pulse
//   edit_data                working value for the display
//   field_sel                0 = seconds, 1 = minutes, 2 = hours
//   editing                  high while in EDIT
module alarm_set #(
    parameter int DEB_MAX = 999999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ALARM_R,
    input  logic        key_sel_n,
    input  logic        key_inc_n,
    input  logic        key_dec_n,
    input  logic        key_ok_n,
    output logic [23:0] alarm_R,
    output logic        alarm_ready_R_clk,
    output logic [23:0] edit_data,
    output logic [1:0]  field_sel,
    output logic        editing
);

    localparam int CW = (DEB_MAX > 0) ? $clog2(DEB_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_MAX);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EDIT   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // Key bundle order: [0]=sel, [1]=inc, [2]=dec, [3]=ok
    logic [3:0]    key_raw_n;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    sync_prev;
    logic [3:0]    filt;
    logic [3:0]    press;
    logic [CW-1:0] cnt [4];

    assign key_raw_n = {key_ok_n, key_dec_n, key_inc_n, key_sel_n};

    // Sync chain idles high (released) so nothing fires coming out of reset.
    // sync_prev only exists to spot a level change; any change restarts the
    // stability count, and once the count saturates the filtered level follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '1;
            sync2     <= '1;
            sync_prev <= '1;
            filt      <= '1;
            press     <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= key_raw_n;
            sync2     <= sync1;
            sync_prev <= sync2;
            press     <= '0;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != sync_prev[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else begin
                    filt[i]  <= sync2[i];
                    // Only the released->pressed filtered edge makes a pulse.
                    press[i] <= filt[i] & ~sync2[i];
                end
            end
        end
    end

    logic sel_p, inc_p, dec_p, ok_p;
    assign sel_p = press[0];
    assign inc_p = press[1];
    assign dec_p = press[2];
    assign ok_p  = press[3];

    // Two-digit BCD step with wrap at fmax; fields never carry into neighbours.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] fmax);
        if (v >= fmax)
            return 8'h00;
        else if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] fmax);
        if (v == 8'h00)
            return fmax;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    logic [7:0] fld_val;
    logic [7:0] fld_max;
    logic [7:0] fld_new;

    always_comb begin
        fld_val = edit_data[23:16];
        case (field_sel)
            2'd0:    fld_val = edit_data[7:0];
            2'd1:    fld_val = edit_data[15:8];
            default: fld_val = edit_data[23:16];
        endcase
        fld_max = (field_sel == 2'd2) ? 8'h23 : 8'h59;
        fld_new = inc_p ? bcd_inc(fld_val, fld_max) : bcd_dec(fld_val, fld_max);
    end

    logic [1:0] state;

    // alarm_R and the ready pulse are registered on the EDIT->COMMIT edge so
    // both are visible during the COMMIT cycle, one cycle after the ok pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            alarm_R           <= '0;
            edit_data         <= '0;
            field_sel         <= '0;
            alarm_ready_R_clk <= 1'b0;
        end else begin
            alarm_ready_R_clk <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ALARM_R) begin
                        state     <= S_EDIT;
                        edit_data <= alarm_R;
                        field_sel <= 2'd0;
                    end
                end
                S_EDIT: begin
                    if (!ALARM_R) begin
                        state <= S_IDLE;
                    end else if (ok_p) begin
                        state             <= S_COMMIT;
                        alarm_R           <= edit_data;
                        alarm_ready_R_clk <= 1'b1;
                    end else if (sel_p) begin
                        field_sel <= (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;
                    end else if (inc_p || dec_p) begin
                        case (field_sel)
                            2'd0:    edit_data[7:0]   <= fld_new;
                            2'd1:    edit_data[15:8]  <= fld_new;
                            2'd2:    edit_data[23:16] <= fld_new;
                            default: ;
                        endcase
                    end
                end
                S_COMMIT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign editing = (state == S_EDIT);

endmodule

// File: tb/tb_alarm_set.sv
// Testbench for alarm_set: random key edits against an integer hh/mm/ss model, plus directed scenarios.
// Latency: keys held 12 cycles low / 12 high per press, well above the DEB_MAX=3 debounce window.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget and a global watchdog.
module tb_alarm_set;

    localparam int DEB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ALARM_R = 1'b0;
    logic        key_sel_n = 1'b1;
    logic        key_inc_n = 1'b1;
    logic        key_dec_n = 1'b1;
    logic        key_ok_n = 1'b1;
    logic [23:0] alarm_R;
    logic        alarm_ready_R_clk;
    logic [23:0] edit_data;
    logic [1:0]  field_sel;
    logic        editing;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;

    // Reference model: plain integers for the working copy and committed alarm.
    int e_h = 0, e_m = 0, e_s = 0;
    int a_h = 0, a_m = 0, a_s = 0;
    int fld = 0;

    alarm_set #(.DEB_MAX(DEB)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ALARM_R           (ALARM_R),
        .key_sel_n         (key_sel_n),
        .key_inc_n         (key_inc_n),
        .key_dec_n         (key_dec_n),
        .key_ok_n          (key_ok_n),
        .alarm_R           (alarm_R),
        .alarm_ready_R_clk (alarm_ready_R_clk),
        .edit_data         (edit_data),
        .field_sel         (field_sel),
        .editing           (editing)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (alarm_ready_R_clk === 1'b1) ready_cnt++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
        logic [23:0] r;
        r = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        return r;
    endfunction

    function automatic int cur_val();
        if (fld == 0) return e_s;
        else if (fld == 1) return e_m;
        else return e_h;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: key_sel_n = v;
            1: key_inc_n = v;
            2: key_dec_n = v;
            default: key_ok_n = v;
        endcase
    endtask

    task automatic model_op(input int k);
        int d;
        if (k == 0) begin
            fld = (fld + 1) % 3;
        end else begin
            d = (k == 1) ? 1 : -1;
            if (fld == 0) e_s = (e_s + 60 + d) % 60;
            else if (fld == 1) e_m = (e_m + 60 + d) % 60;
            else e_h = (e_h + 24 + d) % 24;
        end
    endtask

    // k: 0 = sel, 1 = inc, 2 = dec
    task automatic press(input int k);
        set_key(k, 1'b0);
        cycles(12);
        set_key(k, 1'b1);
        cycles(12);
        model_op(k);
    endtask

    task automatic check_edit(input string name);
        checks++;
        if (edit_data !== to_bcd(e_h, e_m, e_s)) begin
            errors++;
            $display("FAIL %s edit_data: got %h expected %h", name, edit_data, to_bcd(e_h, e_m, e_s));
        end
        checks++;
        if (field_sel !== 2'(fld)) begin
            errors++;
            $display("FAIL %s field_sel: got %0d expected %0d", name, field_sel, fld);
        end
    endtask

    task automatic set_field(input int t, input int v);
        int lim, cur, up;
        while (fld != t) press(0);
        lim = (t == 2) ? 24 : 60;
        cur = cur_val();
        while (cur != v) begin
            up = (v - cur + lim) % lim;
            if (up <= lim / 2) press(1);
            else press(2);
            cur = cur_val();
        end
    endtask

    // Press ok (optionally with inc in the same instant) and follow the commit cycle by cycle.
    task automatic do_commit(input string name, input bit with_inc);
        logic [23:0] old_v, exp_v, prev;
        int start;
        bit found;
        old_v = to_bcd(a_h, a_m, a_s);
        exp_v = to_bcd(e_h, e_m, e_s);
        start = ready_cnt;
        found = 1'b0;
        prev  = alarm_R;
        key_ok_n = 1'b0;
        if (with_inc) key_inc_n = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycles(1);
            if (alarm_ready_R_clk === 1'b1) found = 1'b1;
            else prev = alarm_R;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s ready timeout: got no pulse expected one within 30 cycles", name);
        end
        checks++;
        if (alarm_R !== exp_v) begin
            errors++;
            $display("FAIL %s alarm_R at ready: got %h expected %h", name, alarm_R, exp_v);
        end
        checks++;
        if (prev !== old_v) begin
            errors++;
            $display("FAIL %s alarm_R before ready: got %h expected %h", name, prev, old_v);
        end
        cycles(1);
        checks++;
        if (alarm_ready_R_clk !== 1'b0 || editing !== 1'b0) begin
            errors++;
            $display("FAIL %s idle cycle: got ready=%b editing=%b expected 0 0", name, alarm_ready_R_clk, editing);
        end
        cycles(1);
        checks++;
        if (editing !== 1'b1 || edit_data !== exp_v || field_sel !== 2'd0) begin
            errors++;
            $display("FAIL %s re-edit: got editing=%b edit=%h fs=%0d expected 1 %h 0",
                     name, editing, edit_data, field_sel, exp_v);
        end
        cycles(8);
        key_ok_n  = 1'b1;
        key_inc_n = 1'b1;
        cycles(12);
        checks++;
        if (ready_cnt - start !== 1) begin
            errors++;
            $display("FAIL %s ready count: got %0d expected 1", name, ready_cnt - start);
        end
        a_h = e_h; a_m = e_m; a_s = e_s;
        fld = 0;
    endtask

    task automatic test_reset();
        cycles(3);
        checks++;
        if (alarm_R !== 24'h0 || edit_data !== 24'h0 || field_sel !== 2'd0 ||
            alarm_ready_R_clk !== 1'b0 || editing !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got %h %h %0d %b %b expected all 0",
                     alarm_R, edit_data, field_sel, alarm_ready_R_clk, editing);
        end
        rst_n = 1'b1;
        cycles(10);
        checks++;
        if (alarm_R !== 24'h0 || edit_data !== 24'h0 || editing !== 1'b0 || ready_cnt !== 0) begin
            errors++;
            $display("FAIL reset_release: got %h %h %b ready_cnt=%0d expected 0 0 0 0",
                     alarm_R, edit_data, editing, ready_cnt);
        end
    endtask

    task automatic test_enter();
        ALARM_R = 1'b1;
        cycles(3);
        checks++;
        if (editing !== 1'b1) begin
            errors++;
            $display("FAIL enter editing: got %b expected 1", editing);
        end
        check_edit("enter");
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            key_inc_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycles(2);
        end
        key_inc_n = 1'b0;
        cycles(10);
        key_inc_n = 1'b1;
        cycles(12);
        e_s = 1;
        check_edit("bounce");
    endtask

    task automatic test_wrap();
        press(2);
        press(2);
        check_edit("dec_wrap_sec");
        press(1);
        check_edit("inc_wrap_sec");
        press(0);
        press(0);
        press(2);
        check_edit("dec_wrap_hour");
        press(1);
        check_edit("inc_wrap_hour");
    endtask

    task automatic test_random_edit();
        int k;
        for (int i = 0; i < 25; i++) begin
            k = int'($urandom_range(0, 2));
            press(k);
            check_edit("random");
        end
    endtask

    task automatic test_commit();
        set_field(2, 12);
        set_field(1, 30);
        set_field(0, 45);
        checks++;
        if (edit_data !== 24'h123045) begin
            errors++;
            $display("FAIL commit setup: got %h expected 123045", edit_data);
        end
        do_commit("commit", 1'b0);
        checks++;
        if (alarm_R !== 24'h123045) begin
            errors++;
            $display("FAIL commit value: got %h expected 123045", alarm_R);
        end
    endtask

    task automatic test_priority();
        press(1);
        for (int i = 0; i < 3; i++) press(int'($urandom_range(0, 2)));
        do_commit("priority", 1'b1);
        check_edit("priority_after");
    endtask

    task automatic test_abort();
        logic [23:0] old_v;
        int start;
        set_field(2, 8);
        set_field(1, 0);
        set_field(0, 0);
        checks++;
        if (edit_data !== 24'h080000) begin
            errors++;
            $display("FAIL abort setup: got %h expected 080000", edit_data);
        end
        old_v = to_bcd(a_h, a_m, a_s);
        start = ready_cnt;
        ALARM_R = 1'b0;
        cycles(3);
        checks++;
        if (editing !== 1'b0 || alarm_R !== old_v || ready_cnt !== start) begin
            errors++;
            $display("FAIL abort: got editing=%b alarm=%h readies=%0d expected 0 %h 0",
                     editing, alarm_R, ready_cnt - start, old_v);
        end
        set_key(1, 1'b0);
        cycles(12);
        set_key(1, 1'b1);
        cycles(12);
        checks++;
        if (edit_data !== 24'h080000 || alarm_R !== old_v || editing !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got edit=%h alarm=%h editing=%b expected 080000 %h 0",
                     edit_data, alarm_R, editing, old_v);
        end
        ALARM_R = 1'b1;
        cycles(3);
        e_h = a_h; e_m = a_m; e_s = a_s;
        fld = 0;
        check_edit("abort_reenter");
    endtask

    task automatic test_reset_mid_edit();
        int start;
        press(1);
        start = ready_cnt;
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        checks++;
        if (alarm_R !== 24'h0 || edit_data !== 24'h0 || field_sel !== 2'd0 ||
            alarm_ready_R_clk !== 1'b0 || editing !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h %h %0d %b %b expected all 0",
                     alarm_R, edit_data, field_sel, alarm_ready_R_clk, editing);
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(20);
        e_h = 0; e_m = 0; e_s = 0;
        a_h = 0; a_m = 0; a_s = 0;
        fld = 0;
        check_edit("post_reset");
        checks++;
        if (editing !== 1'b1 || alarm_R !== 24'h0 || ready_cnt !== start) begin
            errors++;
            $display("FAIL post_reset state: got editing=%b alarm=%h readies=%0d expected 1 0 0",
                     editing, alarm_R, ready_cnt - start);
        end
    endtask

    initial begin
        test_reset();
        test_enter();
        test_bounce();
        test_wrap();
        test_random_edit();
        test_commit();
        test_priority();
        test_abort();
        test_reset_mid_edit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
